// File: rtl/arb_fifo_if.sv
// rtl/arb_fifo_if.sv - write/read handshake bundle between arbiter, arb_fifo and master
//
// Purpose: groups the arbiter-side write strobe/fields, the fifo_full
// back-pressure and the master-side head-entry handshake of arb_fifo.
// Signals:
//   slvx_data_valid, slvx_data[DW], slvx_mode[2], slvx_proc_val[8],
//   data_source                                 : arbiter -> FIFO write side
//   fifo_full                                   : FIFO -> arbiter back-pressure
//   mstr_valid, mstr_data[DW], mstr_mode[2],
//   mstr_proc_val[8], mstr_source               : FIFO -> master head entry
//   mstr_ready                                  : master -> FIFO accept
// Modports: slave (the FIFO itself), master (the environment driving it).
interface arb_fifo_if #(
  parameter int DW = 32
);
  logic          slvx_data_valid;
  logic [DW-1:0] slvx_data;
  logic [1:0]    slvx_mode;
  logic [7:0]    slvx_proc_val;
  logic          data_source;
  logic          fifo_full;

  logic          mstr_valid;
  logic          mstr_ready;
  logic [DW-1:0] mstr_data;
  logic [1:0]    mstr_mode;
  logic [7:0]    mstr_proc_val;
  logic          mstr_source;

  modport slave (
    input  slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val, data_source,
    output fifo_full,
    output mstr_valid, mstr_data, mstr_mode, mstr_proc_val, mstr_source,
    input  mstr_ready
  );

  modport master (
    output slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val, data_source,
    input  fifo_full,
    input  mstr_valid, mstr_data, mstr_mode, mstr_proc_val, mstr_source,
    output mstr_ready
  );
endinterface

// File: rtl/arb_fifo.sv
// rtl/arb_fifo.sv - first-word-fall-through FIFO between arbiter and master with frame completion
//
// Purpose: buffers {source, mode, proc_val, data} entries written by the
// arbiter and presents the head entry to the master combinationally from
// registered storage (one-cycle write-to-read latency). Counts pops per
// frame and raises a sticky completion level; flags dropped writes.
// Ports:
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   bus          : arb_fifo_if.slave (write side, fifo_full, head-entry side)
//   frame_len    : entries per frame, 0 disables completion
//   cmplt_clr    : single-cycle clear of mstr0_cmplt (a coincident set wins)
//   mstr0_cmplt  : frame-complete level
//   overflow     : sticky, set by a write attempt while holding DEPTH entries
// Build option: define ARB_FIFO_AFULL_EN to raise fifo_full at DEPTH-2
// entries; writes are still accepted until DEPTH entries are held.
module arb_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  arb_fifo_if.slave     bus,
  input  logic [15:0]   frame_len,
  input  logic          cmplt_clr,
  output logic          mstr0_cmplt,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + 11;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
`ifdef ARB_FIFO_AFULL_EN
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - 2);
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [15:0]   frame_cnt;

  logic          at_depth;
  logic          push;
  logic          pop;
  logic          drop;
  logic          frame_hit;
  logic [EW-1:0] head;

  // Acceptance is tied to real storage capacity, not to fifo_full: in the
  // almost-full build fifo_full rises early while the last two slots remain
  // usable as skid space for the arbiter's late reaction.
  assign at_depth = (count == FULL_CNT);
  assign push     = bus.slvx_data_valid && !at_depth;
  assign drop     = bus.slvx_data_valid && at_depth;
  assign pop      = bus.mstr_valid && bus.mstr_ready;

`ifdef ARB_FIFO_AFULL_EN
  assign bus.fifo_full = (count >= AFULL_CNT);
`else
  assign bus.fifo_full = at_depth;
`endif

  // Head entry falls through from the read pointer; fields are meaningless
  // while mstr_valid is low since storage is never cleared.
  assign head              = mem[rd_ptr];
  assign bus.mstr_valid    = (count != '0);
  assign bus.mstr_source   = head[DW+10];
  assign bus.mstr_mode     = head[DW+9:DW+8];
  assign bus.mstr_proc_val = head[DW+7:DW];
  assign bus.mstr_data     = head[DW-1:0];

  // Storage has no reset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.data_source, bus.slvx_mode, bus.slvx_proc_val, bus.slvx_data};
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers are exactly AW bits so they wrap DEPTH-1 -> 0 on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Completion compares against the live frame_len. If frame_len is lowered
  // below the current count the equality is missed and the counter must run
  // through its 16-bit wrap before it can match again.
  assign frame_hit = pop && (frame_len != 16'd0) && (frame_cnt == frame_len - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pop && (frame_len != 16'd0)) begin
      if (frame_hit) frame_cnt <= '0;
      else           frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Set has priority so a completion is never lost to a stale clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstr0_cmplt <= 1'b0;
    end else if (frame_hit) begin
      mstr0_cmplt <= 1'b1;
    end else if (cmplt_clr) begin
      mstr0_cmplt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_fifo.sv
// tb/tb_arb_fifo.sv - self-checking bench for arb_fifo with queue-based reference model
module tb_arb_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
`ifdef ARB_FIFO_AFULL_EN
  localparam int FULL_AT = DEPTH - 2;
`else
  localparam int FULL_AT = DEPTH;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] frame_len;
  logic        cmplt_clr;
  logic        mstr0_cmplt;
  logic        overflow;

  arb_fifo_if #(.DW(DW)) bus ();

  arb_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .frame_len   (frame_len),
    .cmplt_clr   (cmplt_clr),
    .mstr0_cmplt (mstr0_cmplt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {source, mode, proc_val, data} entries plus
  // plain counters, advanced once per rising edge from the inputs held there.
  logic [DW+10:0] mq[$];
  bit             m_ovf;
  bit             m_cmplt;
  int             m_fcnt;
  bit             m_pop, m_push, m_set;
  int             m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf   = 0;
      m_cmplt = 0;
      m_fcnt  = 0;
    end else begin
      m_n    = mq.size();
      m_pop  = (m_n != 0) && bus.mstr_ready;
      m_push = bus.slvx_data_valid && (m_n < DEPTH);
      m_set  = 0;
      if (bus.slvx_data_valid && m_n == DEPTH) m_ovf = 1;
      if (m_pop) begin
        void'(mq.pop_front());
        if (frame_len != 0) begin
          if (m_fcnt + 1 == int'(frame_len)) begin
            m_fcnt = 0;
            m_set  = 1;
          end else begin
            m_fcnt = (m_fcnt + 1) % 65536;
          end
        end
      end
      if (m_push) mq.push_back({bus.data_source, bus.slvx_mode, bus.slvx_proc_val, bus.slvx_data});
      if (m_set) m_cmplt = 1;
      else if (cmplt_clr) m_cmplt = 0;
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_valid", 64'(bus.mstr_valid), 64'(mq.size() != 0));
      check("mdl_full", 64'(bus.fifo_full), 64'(mq.size() >= FULL_AT));
      check("mdl_ovf", 64'(overflow), 64'(m_ovf));
      check("mdl_cmplt", 64'(mstr0_cmplt), 64'(m_cmplt));
      if (mq.size() != 0) begin
        check("mdl_head", 64'({bus.mstr_source, bus.mstr_mode, bus.mstr_proc_val, bus.mstr_data}),
              64'(mq[0]));
      end
    end
  end

  // One clock: inputs are applied here, held across the edge, and the task
  // returns 2 time units after that edge.
  task automatic cyc(input bit vld, input logic [31:0] d, input logic [1:0] md,
                     input logic [7:0] pv, input bit src, input bit rdy, input bit clr);
    bus.slvx_data_valid = vld;
    bus.slvx_data       = d;
    bus.slvx_mode       = md;
    bus.slvx_proc_val   = pv;
    bus.data_source     = src;
    bus.mstr_ready      = rdy;
    cmplt_clr           = clr;
    @(posedge clk);
    #2;
    bus.slvx_data_valid = 1'b0;
    bus.mstr_ready      = 1'b0;
    cmplt_clr           = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    frame_len = 16'd0;
    cmplt_clr = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n               = 1'b0;
    frame_len           = 16'd0;
    cmplt_clr           = 1'b0;
    bus.slvx_data_valid = 1'b0;
    bus.slvx_data       = '0;
    bus.slvx_mode       = '0;
    bus.slvx_proc_val   = '0;
    bus.data_source     = 1'b0;
    bus.mstr_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 64'(bus.mstr_valid), 64'd0);
    check("rst_full", 64'(bus.fifo_full), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_cmplt", 64'(mstr0_cmplt), 64'd0);
    rst_n  = 1'b1;
    chk_en = 1;

    // Latency: single write visible after one edge, then popped away.
    cyc(1, 32'hA5A5A5A5, 2'd2, 8'h3C, 1, 0, 0);
    check("lat_valid", 64'(bus.mstr_valid), 64'd1);
    check("lat_data", 64'(bus.mstr_data), 64'hA5A5A5A5);
    check("lat_mode", 64'(bus.mstr_mode), 64'd2);
    check("lat_src", 64'(bus.mstr_source), 64'd1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("lat_empty", 64'(bus.mstr_valid), 64'd0);

    // Fill: 17 writes with no reads; the 17th is dropped.
    for (int i = 0; i < 17; i++) begin
      cyc(1, 32'(i), 2'(i % 4), 8'(i), bit'(i % 2), 0, 0);
`ifdef ARB_FIFO_AFULL_EN
      if (i == 13) check("fill_afull14", 64'(bus.fifo_full), 64'd1);
      if (i < 15) check("fill_no_ovf", 64'(overflow), 64'd0);
`endif
      if (i == 15) check("fill_full16", 64'(bus.fifo_full), 64'd1);
    end
    check("fill_ovf", 64'(overflow), 64'd1);
    check("fill_full", 64'(bus.fifo_full), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check("fill_order", 64'(bus.mstr_data), 64'(i));
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    check("fill_drained", 64'(bus.mstr_valid), 64'd0);

    // Streaming near full: 15 held, push and pop together for 40 cycles.
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1, 32'(100 + i), 2'd1, 8'(i), 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      check("strm_order", 64'(bus.mstr_data), (k < 15) ? 64'(100 + k) : 64'(200 + k - 15));
      cyc(1, 32'(200 + k), 2'd3, 8'(k), 1, 1, 0);
    end
    check("strm_ovf", 64'(overflow), 64'd0);
    check("strm_valid", 64'(bus.mstr_valid), 64'd1);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 1, 0);

    // Frame completion, clear, set-beats-clear, and frame_len lowered mid-frame.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 32'(300 + i), 2'd0, 8'd0, 0, 0, 0);
    frame_len = 16'd4;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    check("frm_not_yet", 64'(mstr0_cmplt), 64'd0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("frm_set", 64'(mstr0_cmplt), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("frm_clr", 64'(mstr0_cmplt), 64'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    check("frm_mid", 64'(mstr0_cmplt), 64'd0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    check("frm_set_wins", 64'(mstr0_cmplt), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    frame_len = 16'd2;
    for (int i = 0; i < 3; i++) cyc(1, 32'(400 + i), 2'd0, 8'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    check("frm_shrunk", 64'(mstr0_cmplt), 64'd0);

    // Asynchronous reset at count 9 with overflow and completion both set.
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1, 32'(500 + i), 2'd2, 8'd7, 1, 0, 0);
    frame_len = 16'd7;
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    check("pre_rst_cmplt", 64'(mstr0_cmplt), 64'd1);
    check("pre_rst_ovf", 64'(overflow), 64'd1);
    bus.slvx_data_valid = 1'b1;
    bus.mstr_ready      = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.mstr_valid), 64'd0);
    check("arst_full", 64'(bus.fifo_full), 64'd0);
    check("arst_cmplt", 64'(mstr0_cmplt), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    bus.slvx_data_valid = 1'b0;
    bus.mstr_ready      = 1'b0;
    frame_len           = 16'd0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(1, 32'h77, 2'd1, 8'h11, 0, 0, 0);
    check("post_rst_head", 64'(bus.mstr_data), 64'h77);
    check("post_rst_valid", 64'(bus.mstr_valid), 64'd1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("post_rst_empty", 64'(bus.mstr_valid), 64'd0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
